// File: rtl/cmul_pkg.sv
// cmul_pkg: shared constants and helpers for the cmul_pipe complex multiplier.
//   N    : word width of each real/imag component
//   Q    : fraction bits of the Q-format operands and result
//   PW   : width of one full signed product (2N)
//   SW   : width of a sum of two products plus rounding headroom (2N+2)
//   RND  : round-half-up constant added before the right shift by Q
//   MAXV/MINV     : N-bit output clamp values
//   MAXV_W/MINV_W : the same limits sign-extended to SW bits for comparison
// Build option: define CMUL_SAT_EN to clamp out-of-range results (default wraps).
package cmul_pkg;

    localparam int N  = 16;
    localparam int Q  = 8;
    localparam int PW = 2 * N;
    localparam int SW = 2 * N + 2;

    localparam logic signed [SW-1:0] RND    = SW'(1) << (Q - 1);
    localparam logic signed [N-1:0]  MAXV   = {1'b0, {(N-1){1'b1}}};
    localparam logic signed [N-1:0]  MINV   = {1'b1, {(N-1){1'b0}}};
    localparam logic signed [SW-1:0] MAXV_W = {{(SW-N+1){1'b0}}, {(N-1){1'b1}}};
    localparam logic signed [SW-1:0] MINV_W = {{(SW-N+1){1'b1}}, {(N-1){1'b0}}};

    // Full-precision signed product; operands are widened first so the
    // multiply is done at PW bits and nothing is lost.
    function automatic logic signed [PW-1:0] smul(input logic signed [N-1:0] x,
                                                  input logic signed [N-1:0] y);
        logic signed [PW-1:0] xe;
        logic signed [PW-1:0] ye;
        xe = {{N{x[N-1]}}, x};
        ye = {{N{y[N-1]}}, y};
        return xe * ye;
    endfunction

    function automatic logic signed [SW-1:0] sext_p(input logic signed [PW-1:0] p);
        return {{(SW-PW){p[PW-1]}}, p};
    endfunction

endpackage

// File: rtl/cmul_if.sv
// cmul_if: operand/result bus of cmul_pipe.
//   in_valid/in_ready   : operand handshake (a_re, a_im, b_re, b_im, conj_b)
//   out_valid/out_ready : result handshake (p_re, p_im)
//   ovf (sticky overflow flag), ovf_clr (synchronous clear)
// Handshake: a word moves across a channel on a rising clock edge where both
// valid and ready are 1. A source holds valid and its data unchanged until the
// word is taken; a sink may raise or drop ready at any time.
// master = the block feeding operands and consuming results; slave = cmul_pipe.
// Build option: CMUL_SAT_EN (affects cmul_pipe only).
interface cmul_if;

    logic                   in_valid;
    logic                   in_ready;
    logic [cmul_pkg::N-1:0] a_re;
    logic [cmul_pkg::N-1:0] a_im;
    logic [cmul_pkg::N-1:0] b_re;
    logic [cmul_pkg::N-1:0] b_im;
    logic                   conj_b;
    logic                   out_valid;
    logic                   out_ready;
    logic [cmul_pkg::N-1:0] p_re;
    logic [cmul_pkg::N-1:0] p_im;
    logic                   ovf;
    logic                   ovf_clr;

    modport master (
        output in_valid, a_re, a_im, b_re, b_im, conj_b, out_ready, ovf_clr,
        input  in_ready, out_valid, p_re, p_im, ovf
    );

    modport slave (
        input  in_valid, a_re, a_im, b_re, b_im, conj_b, out_ready, ovf_clr,
        output in_ready, out_valid, p_re, p_im, ovf
    );

endinterface

// File: rtl/cmul_round_sat.sv
// cmul_round_sat: final reduction of one result component.
//   sum_i : SW-bit signed sum that already includes the rounding constant
//   val_o : N-bit result after arithmetic shift by Q (clamped or wrapped)
//   ovf_o : shifted value fell outside the N-bit signed range
// Build option: CMUL_SAT_EN defined -> clamp; undefined -> keep low N bits.
module cmul_round_sat
    import cmul_pkg::*;
(
    input  logic signed [SW-1:0] sum_i,
    output logic        [N-1:0]  val_o,
    output logic                 ovf_o
);

    logic signed [SW-1:0] shifted;
    logic                 too_big;
    logic                 too_small;

    always_comb begin
        shifted   = sum_i >>> Q;
        too_big   = shifted > MAXV_W;
        too_small = shifted < MINV_W;
        ovf_o     = too_big | too_small;
`ifdef CMUL_SAT_EN
        if (too_big) begin
            val_o = MAXV;
        end else if (too_small) begin
            val_o = MINV;
        end else begin
            val_o = shifted[N-1:0];
        end
`else
        val_o = shifted[N-1:0];
`endif
    end

endmodule

// File: rtl/cmul_pipe.sv
// cmul_pipe: three-stage pipelined Q-format complex multiplier,
// P = A * B, or A * conj(B) when conj_b is set with the operands.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset, clears every stage
//   bus   : cmul_if.slave (operands, results, handshake, ovf/ovf_clr)
// Stages: S1 products, S2 rounded sums, S3 shift + reduce + output register.
// The whole pipe advances together on en = !out_valid | out_ready, so a
// stalled output freezes every stage and bubbles are kept in place.
// Build option: CMUL_SAT_EN selects saturating instead of wrapping results.
module cmul_pipe
    import cmul_pkg::*;
(
    input  logic   clk,
    input  logic   rst_n,
    cmul_if.slave  bus
);

    logic                 en;

    // S1
    logic                 s1_valid_q;
    logic                 conj_q;
    logic signed [PW-1:0] rr_d, ii_d, ri_d, ir_d;
    logic signed [PW-1:0] rr_q, ii_q, ri_q, ir_q;

    // S2
    logic                 s2_valid_q;
    logic signed [SW-1:0] re_sum_d, im_sum_d;
    logic signed [SW-1:0] re_sum_q, im_sum_q;

    // S3
    logic                 out_valid_q;
    logic        [N-1:0]  re_red, im_red;
    logic                 re_ovf, im_ovf;
    logic        [N-1:0]  p_re_q, p_im_q;
    logic                 ovf_d, ovf_q;

    assign en           = !out_valid_q || bus.out_ready;
    assign bus.in_ready = en;
    assign bus.out_valid = out_valid_q;
    assign bus.p_re     = p_re_q;
    assign bus.p_im     = p_im_q;
    assign bus.ovf      = ovf_q;

    always_comb begin
        rr_d = smul(bus.a_re, bus.b_re);
        ii_d = smul(bus.a_im, bus.b_im);
        ri_d = smul(bus.a_re, bus.b_im);
        ir_d = smul(bus.a_im, bus.b_re);
    end

    // Conjugation flips the sign of the b_im products rather than b_im
    // itself, so b_im = most-negative value stays exact.
    always_comb begin
        re_sum_d = '0;
        im_sum_d = '0;
        if (conj_q) begin
            re_sum_d = sext_p(rr_q) + sext_p(ii_q);
            im_sum_d = sext_p(ir_q) - sext_p(ri_q);
        end else begin
            re_sum_d = sext_p(rr_q) - sext_p(ii_q);
            im_sum_d = sext_p(ri_q) + sext_p(ir_q);
        end
        re_sum_d = re_sum_d + RND;
        im_sum_d = im_sum_d + RND;
    end

    cmul_round_sat u_rs_re (
        .sum_i (re_sum_q),
        .val_o (re_red),
        .ovf_o (re_ovf)
    );

    cmul_round_sat u_rs_im (
        .sum_i (im_sum_q),
        .val_o (im_red),
        .ovf_o (im_ovf)
    );

    // Sticky flag: a result overflowing in the same cycle as ovf_clr wins.
    always_comb begin
        ovf_d = ovf_q;
        if (bus.ovf_clr) begin
            ovf_d = 1'b0;
        end
        if (en && s2_valid_q && (re_ovf || im_ovf)) begin
            ovf_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q  <= 1'b0;
            conj_q      <= 1'b0;
            rr_q        <= '0;
            ii_q        <= '0;
            ri_q        <= '0;
            ir_q        <= '0;
            s2_valid_q  <= 1'b0;
            re_sum_q    <= '0;
            im_sum_q    <= '0;
            out_valid_q <= 1'b0;
            p_re_q      <= '0;
            p_im_q      <= '0;
            ovf_q       <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
            if (en) begin
                s1_valid_q  <= bus.in_valid;
                conj_q      <= bus.conj_b;
                rr_q        <= rr_d;
                ii_q        <= ii_d;
                ri_q        <= ri_d;
                ir_q        <= ir_d;
                s2_valid_q  <= s1_valid_q;
                re_sum_q    <= re_sum_d;
                im_sum_q    <= im_sum_d;
                out_valid_q <= s2_valid_q;
                // Keep the last real result on the bus across bubbles.
                if (s2_valid_q) begin
                    p_re_q <= re_red;
                    p_im_q <= im_red;
                end
            end
        end
    end

endmodule

// File: tb/tb_cmul_pipe.sv
// tb_cmul_pipe: directed and randomized checks of cmul_pipe (N=16, Q=8)
// against an integer-arithmetic reference of the complex product.
module tb_cmul_pipe;

    logic clk = 1'b0;
    logic rst_n;

    cmul_if bus ();

    cmul_pipe dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // {ovf, re, im}
    logic [32:0] exp_q[$];
    logic        exp_sticky;
    logic        stall_prev;
    logic [15:0] held_re, held_im;
    logic [15:0] last_re, last_im;
    int          n_out;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Range-reduce one exact component: {overflow, N-bit result}.
    function automatic logic [16:0] reduce(input longint v);
        logic        o;
        logic [15:0] r;
        o = (v > 32767) || (v < -32768);
        r = v[15:0];
`ifdef CMUL_SAT_EN
        if (v > 32767)  r = 16'h7FFF;
        if (v < -32768) r = 16'h8000;
`endif
        return {o, r};
    endfunction

    function automatic logic [32:0] model(input logic [15:0] ar, input logic [15:0] ai,
                                          input logic [15:0] br, input logic [15:0] bi,
                                          input logic cj);
        longint xr, xi, yr, yi, re, im;
        logic [16:0] r, i;
        xr = longint'($signed(ar));
        xi = longint'($signed(ai));
        yr = longint'($signed(br));
        yi = longint'($signed(bi));
        if (cj) begin
            re = xr * yr + xi * yi;
            im = xi * yr - xr * yi;
        end else begin
            re = xr * yr - xi * yi;
            im = xr * yi + xi * yr;
        end
        re = (re + 128) >>> 8;
        im = (im + 128) >>> 8;
        r = reduce(re);
        i = reduce(im);
        return {r[16] | i[16], r[15:0], i[15:0]};
    endfunction

    task automatic drive(input logic [15:0] ar, input logic [15:0] ai,
                         input logic [15:0] br, input logic [15:0] bi, input logic cj);
        bus.in_valid = 1'b1;
        bus.a_re     = ar;
        bus.a_im     = ai;
        bus.b_re     = br;
        bus.b_im     = bi;
        bus.conj_b   = cj;
    endtask

    // One clock cycle: inputs are already set; observe, score, advance.
    task automatic tick(output logic acc);
        logic [32:0] e;
        #1;
        acc = bus.in_valid && bus.in_ready;
        check("in_ready", 32'(bus.in_ready), 32'(!bus.out_valid || bus.out_ready));
        if (stall_prev) begin
            check("hold_valid", 32'(bus.out_valid), 32'd1);
            check("hold_re", 32'(bus.p_re), 32'(held_re));
            check("hold_im", 32'(bus.p_im), 32'(held_im));
        end
        if (acc) begin
            exp_q.push_back(model(bus.a_re, bus.a_im, bus.b_re, bus.b_im, bus.conj_b));
        end
        if (bus.out_valid && bus.out_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_out", 32'(exp_q.size()), 32'd1);
            end else begin
                e = exp_q.pop_front();
                check("p_re", 32'(bus.p_re), 32'(e[31:16]));
                check("p_im", 32'(bus.p_im), 32'(e[15:0]));
                exp_sticky = exp_sticky | e[32];
                check("ovf_sticky", 32'(bus.ovf), 32'(exp_sticky));
                last_re = bus.p_re;
                last_im = bus.p_im;
                n_out++;
            end
        end
        stall_prev = bus.out_valid && !bus.out_ready;
        held_re    = bus.p_re;
        held_im    = bus.p_im;
        @(posedge clk);
        #1;
    endtask

    // Single operand into an empty pipe; verifies the 3-cycle latency.
    task automatic single(input logic [15:0] ar, input logic [15:0] ai,
                          input logic [15:0] br, input logic [15:0] bi, input logic cj);
        logic acc;
        int   lat;
        drive(ar, ai, br, bi, cj);
        bus.out_ready = 1'b1;
        tick(acc);
        check("accept", 32'(acc), 32'd1);
        bus.in_valid = 1'b0;
        lat = 1;
        while (!bus.out_valid && lat < 10) begin
            tick(acc);
            lat++;
        end
        check("latency", lat, 3);
        tick(acc);
    endtask

    logic [15:0] tab_ar[10], tab_ai[10], tab_br[10], tab_bi[10];
    logic        tab_cj[10];

    function automatic logic [15:0] rnd_word();
        if ($urandom_range(0, 7) == 0) return 16'h8000;
        return 16'($urandom_range(0, 65535));
    endfunction

    initial begin
        logic acc;
        int   idx, cyc, n0;
        logic pending;

        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.a_re      = '0;
        bus.a_im      = '0;
        bus.b_re      = '0;
        bus.b_im      = '0;
        bus.conj_b    = 1'b0;
        bus.out_ready = 1'b0;
        bus.ovf_clr   = 1'b0;
        exp_sticky    = 1'b0;
        stall_prev    = 1'b0;
        held_re       = '0;
        held_im       = '0;
        last_re       = '0;
        last_im       = '0;
        n_out         = 0;

        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_p_re", 32'(bus.p_re), 32'd0);
        check("rst_p_im", 32'(bus.p_im), 32'd0);
        check("rst_ovf", 32'(bus.ovf), 32'd0);
        check("rst_in_ready", 32'(bus.in_ready), 32'd1);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // (1+j)(1-j) = 2
        single(16'h0100, 16'h0100, 16'h0100, 16'hFF00, 1'b0);
        check("t1_re", 32'(last_re), 32'h0200);
        check("t1_im", 32'(last_im), 32'h0000);
        check("t1_ovf", 32'(bus.ovf), 32'd0);

        // j * conj(j) = 1, j * j = -1
        single(16'h0000, 16'h0100, 16'h0000, 16'h0100, 1'b1);
        check("conj_re", 32'(last_re), 32'h0100);
        check("conj_im", 32'(last_im), 32'h0000);
        single(16'h0000, 16'h0100, 16'h0000, 16'h0100, 1'b0);
        check("noconj_re", 32'(last_re), 32'hFF00);
        check("noconj_im", 32'(last_im), 32'h0000);

        // Round half up
        single(16'h0001, 16'h0000, 16'h0080, 16'h0000, 1'b0);
        check("rnd_pos", 32'(last_re), 32'h0001);
        single(16'hFFFF, 16'h0000, 16'h0080, 16'h0000, 1'b0);
        check("rnd_neg", 32'(last_re), 32'h0000);

        // Overflow, sticky until cleared
        single(16'h7F00, 16'h0000, 16'h0200, 16'h0000, 1'b0);
`ifdef CMUL_SAT_EN
        check("ovf_re", 32'(last_re), 32'h7FFF);
`else
        check("ovf_re", 32'(last_re), 32'hFE00);
`endif
        check("ovf_set", 32'(bus.ovf), 32'd1);
        repeat (3) tick(acc);
        check("ovf_held", 32'(bus.ovf), 32'd1);
        bus.ovf_clr = 1'b1;
        tick(acc);
        bus.ovf_clr = 1'b0;
        exp_sticky  = 1'b0;
        check("ovf_clr", 32'(bus.ovf), 32'd0);

        // Clear in the same cycle as a new overflow: set wins
        drive(16'h7F00, 16'h0000, 16'h0200, 16'h0000, 1'b0);
        tick(acc);
        bus.in_valid = 1'b0;
        tick(acc);
        bus.ovf_clr = 1'b1;
        tick(acc);
        bus.ovf_clr = 1'b0;
        check("set_wins", 32'(bus.ovf), 32'd1);
        tick(acc);
        bus.ovf_clr = 1'b1;
        tick(acc);
        bus.ovf_clr = 1'b0;
        exp_sticky  = 1'b0;
        check("ovf_clr2", 32'(bus.ovf), 32'd0);

        // Backpressure: 10 back-to-back operands, out_ready toggles every 2 cycles
        for (int i = 0; i < 10; i++) begin
            tab_ar[i] = 16'($urandom_range(0, 65535));
            tab_ai[i] = 16'($urandom_range(0, 65535));
            tab_br[i] = 16'($urandom_range(0, 65535));
            tab_bi[i] = 16'($urandom_range(0, 65535));
            tab_cj[i] = 1'($urandom_range(0, 1));
        end
        n0  = n_out;
        idx = 0;
        cyc = 0;
        while ((idx < 10 || exp_q.size() > 0) && cyc < 200) begin
            if (idx < 10) drive(tab_ar[idx], tab_ai[idx], tab_br[idx], tab_bi[idx], tab_cj[idx]);
            else          bus.in_valid = 1'b0;
            bus.out_ready = ((cyc / 2) % 2) == 1;
            tick(acc);
            if (acc) idx++;
            cyc++;
        end
        check("bp_count", n_out - n0, 10);
        check("bp_drained", 32'(exp_q.size()), 32'd0);

        // Randomized traffic
        pending = 1'b0;
        for (int c = 0; c < 400; c++) begin
            if (!pending) begin
                if ($urandom_range(0, 3) != 0) begin
                    drive(rnd_word(), rnd_word(), rnd_word(), rnd_word(), 1'($urandom_range(0, 1)));
                end else begin
                    bus.in_valid = 1'b0;
                end
            end
            bus.out_ready = $urandom_range(0, 3) != 0;
            tick(acc);
            pending = bus.in_valid && !acc;
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        cyc = 0;
        while (exp_q.size() > 0 && cyc < 20) begin
            tick(acc);
            cyc++;
        end
        check("rand_drained", 32'(exp_q.size()), 32'd0);

        // Reset with three operands in flight (ovf set beforehand)
        single(16'h7F00, 16'h0000, 16'h0200, 16'h0000, 1'b0);
        for (int i = 0; i < 3; i++) begin
            drive(16'h0100 + 16'(i), 16'h0020, 16'h0100, 16'h0040, 1'b0);
            tick(acc);
        end
        bus.in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        check("mid_rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("mid_rst_ovf", 32'(bus.ovf), 32'd0);
        check("mid_rst_p_re", 32'(bus.p_re), 32'd0);
        exp_q.delete();
        exp_sticky = 1'b0;
        stall_prev = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        single(16'h0100, 16'h0000, 16'h0300, 16'h0000, 1'b0);
        check("post_rst_re", 32'(last_re), 32'h0300);
        check("post_rst_im", 32'(last_im), 32'h0000);
        check("post_rst_drained", 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

endmodule
